inst_fetch: RTL and testbench

//  Instruction-fetch stage feeding CONTROLLER and the decode/SEXT path of the miniRVCPU core.

---
 rtl/inst_fetch.sv | 153 +++++++++++++++
 tb/tb_inst_fetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction-fetch stage: PC register, IMEM req/ack fetch, next-PC select and misalignment trap
//
// Purpose:
//   Holds the architectural PC and fetches one instruction word per
//   instruction from IMEM. The instruction is presented with inst_valid.
//   When it leaves EXEC, the next PC is selected by npc_op.
//   A misaligned next PC traps into a terminal ERR state until reset.
//
// Optional feature macro: IFETCH_INSTRET_EN (adds the instret retired-instruction counter port)
//
// Parameters:
//   RESET_PC    PC loaded on reset; this is also the first fetch address
//   NOP_INST    value driven on inst when no valid instruction is held
//
// Ports:
//   clk         in   1   core clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   npc_op      in   2   next-PC select: 0 = pc+4, 1 = pc+imm, 2 = (rd1+imm)&~1, 3 = pc+4
//   imm         in   32  sign-extended immediate
//   rd1         in   32  register-file read data 1 (jalr base)
//   stall       in   1   hold the current instruction in EXEC
//   imem_ack    in   1   imem_rdata is valid this cycle
//   imem_rdata  in   32  IMEM read data
//   imem_req    out  1   IMEM request, decoded from the state register
//   imem_addr   out  32  IMEM address (equal to pc)
//   pc          out  32  PC of the instruction in flight
//   pc4         out  32  pc + 4, wrapping
//   inst        out  32  fetched instruction, stable while inst_valid = 1
//   inst_valid  out  1   inst holds a valid instruction
//   fetch_err   out  1   sticky misaligned-target trap flag
//   instret     out  32  retired-instruction count (only with IFETCH_INSTRET_EN)

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] rd1,
    input  logic        stall,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_err
`ifdef IFETCH_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam logic [1:0] PC_4    = 2'd0;
    localparam logic [1:0] PC_IMM  = 2'd1;
    localparam logic [1:0] RD1_IMM = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] npc;
    logic        npc_aligned;
    logic        advance;
    logic        trap;

    always_comb begin
        npc = pc + 32'd4;
        case (npc_op)
            PC_4:    npc = pc + 32'd4;
            PC_IMM:  npc = pc + imm;
            RD1_IMM: npc = (rd1 + imm) & ~32'h1;
            default: npc = pc + 32'd4;
        endcase
    end

    assign npc_aligned = (npc[1:0] == 2'b00);
    // An instruction leaves EXEC only when it is not stalled. It then either
    // retires to an aligned target or traps on a misaligned one.
    assign advance     = (state == EXEC) && !stall && npc_aligned;
    assign trap        = (state == EXEC) && !stall && !npc_aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (imem_ack) state_nxt = EXEC;
            EXEC: begin
                if (advance) begin
                    state_nxt = REQ;
                end else if (trap) begin
                    state_nxt = ERR;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            inst      <= NOP_INST;
            fetch_err <= 1'b0;
        end else begin
            if (state == REQ && imem_ack) begin
                inst <= imem_rdata;
            end
            if (advance) begin
                pc   <= npc;
                inst <= NOP_INST;
            end
            if (trap) begin
                fetch_err <= 1'b1;
            end
        end
    end

`ifdef IFETCH_INSTRET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 32'd0;
        end else if (advance) begin
            instret <= instret + 32'd1;
        end
    end
`endif

    // Request and valid are decoded from the state register, so an
    // asynchronous reset drops them immediately without waiting for a clock edge.
    assign imem_req   = (state == REQ);
    assign inst_valid = (state == EXEC);
    assign imem_addr  = pc;
    assign pc4        = pc + 32'd4;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch: directed scenarios plus randomized run against a behavioural model

module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  npc_op = 2'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rd1 = 32'd0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;
`ifdef IFETCH_INSTRET_EN
    logic [31:0] instret;
`endif

    inst_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc_op     (npc_op),
        .imm        (imm),
        .rd1        (rd1),
        .stall      (stall),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .pc4        (pc4),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err)
`ifdef IFETCH_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction lifecycle is tracked as waiting (the cycle after
    // reset), fetching, holding the instruction, or trapped.
    localparam int M_WAIT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HOLD  = 2;
    localparam int M_TRAP  = 3;

    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_ret;
    logic        m_err;

    function automatic logic [31:0] target(input logic [1:0] op, input logic [31:0] p,
                                           input logic [31:0] im, input logic [31:0] r);
        if (op == 2'd1) return p + im;
        if (op == 2'd2) return (r + im) & ~32'h1;
        return p + 32'd4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] t;
        if (!rst_n) begin
            m_phase = M_WAIT;
            m_pc    = 32'd0;
            m_inst  = NOP;
            m_ret   = 32'd0;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                M_WAIT:  m_phase = M_FETCH;
                M_FETCH: if (imem_ack) begin
                    m_inst  = imem_rdata;
                    m_phase = M_HOLD;
                end
                M_HOLD: if (!stall) begin
                    t = target(npc_op, m_pc, imm, rd1);
                    if (t % 4 == 0) begin
                        m_pc    = t;
                        m_inst  = NOP;
                        m_ret   = m_ret + 1;
                        m_phase = M_FETCH;
                    end else begin
                        m_err   = 1'b1;
                        m_phase = M_TRAP;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        check("req",        imem_req,   32'(m_phase == M_FETCH));
        check("valid",      inst_valid, 32'(m_phase == M_HOLD));
        check("addr",       imem_addr,  m_pc);
        check("pc",         pc,         m_pc);
        check("pc4",        pc4,        m_pc + 32'd4);
        check("inst",       inst,       m_inst);
        check("fetch_err",  fetch_err,  32'(m_err));
`ifdef IFETCH_INSTRET_EN
        check("instret",    instret,    m_ret);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a request, acks after `delay` cycles, and returns the requested address.
    task automatic do_fetch(input logic [31:0] data, input int delay, output logic [31:0] addr);
        int n = 0;
        imem_ack = 1'b0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: imem_req stayed 0 for 20 cycles");
        end
        addr = imem_addr;
        repeat (delay) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic retire(input logic [1:0] op, input logic [31:0] im, input logic [31:0] r);
        stall  = 1'b0;
        npc_op = op;
        imm    = im;
        rd1    = r;
        tick();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] held;
        int r;

        rst_n = 1'b0;
        tick();
        tick();
        check("rst_pc",    pc,         32'h0);
        check("rst_inst",  inst,       32'h13);
        check("rst_valid", inst_valid, 32'h0);
        check("rst_req",   imem_req,   32'h0);
        check("rst_err",   fetch_err,  32'h0);
        rst_n = 1'b1;

        // T1
        do_fetch(32'h0050_0093, 2, a);
        check("t1_addr",  a,          32'h0);
        check("t1_valid", inst_valid, 32'h1);
        check("t1_inst",  inst,       32'h0050_0093);
        retire(2'd0, 32'd0, 32'd0);
        do_fetch(32'h0000_0013, 1, a);
        check("t1_next_addr", a, 32'h4);

        // T2
        retire(2'd1, 32'hC, 32'd0);
        do_fetch(32'h1111_1111, 0, a);
        check("t2_pc10", a, 32'h10);
        retire(2'd1, 32'hFFFF_FFF8, 32'd0);
        do_fetch(32'h2222_2222, 3, a);
        check("t2_back", a, 32'h08);

        // T4: stall
        held  = inst;
        stall = 1'b1;
        npc_op = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_valid", inst_valid, 32'h1);
            check("t4_req",   imem_req,   32'h0);
            check("t4_pc",    pc,         32'h08);
            check("t4_inst",  inst,       held);
        end

        // T3: jalr, with a same-cycle ack on the fetch
        retire(2'd2, 32'h3, 32'h1001);
        do_fetch(32'h3333_3333, 0, a);
        check("t3_jalr",       a,          32'h1004);
        check("t4_same_cycle", inst_valid, 32'h1);
        retire(2'd2, 32'h2, 32'h100);
        check("t3_err",   fetch_err, 32'h1);
        check("t3_req",   imem_req,  32'h0);
        check("t3_pc",    pc,        32'h1004);
        tick();
        tick();
        check("t3_err_sticky", fetch_err,  32'h1);
        check("t3_req_stays",  imem_req,   32'h0);
        check("t3_no_valid",   inst_valid, 32'h0);

        // T6: wrap, then count retired instructions
        pulse_reset();
        do_fetch(32'h13, 1, a);
        retire(2'd2, 32'h0, 32'hFFFF_FFFC);
        do_fetch(32'h13, 1, a);
        check("t6_fffc", a, 32'hFFFF_FFFC);
        retire(2'd0, 32'd0, 32'd0);
        do_fetch(32'h13, 2, a);
        check("t6_wrap", a, 32'h0);
        for (int i = 0; i < 3; i++) begin
            retire(2'd3, 32'd0, 32'd0);
            do_fetch(32'h13, i, a);
        end
        check("t6_op3_pc", a, 32'hC);
`ifdef IFETCH_INSTRET_EN
        check("t6_instret5", instret, 32'd5);
        retire(2'd2, 32'h1, 32'h0);
        check("t6_instret_trap", instret, 32'd5);
        check("t6_trap_err",     fetch_err, 32'h1);
        pulse_reset();
        tick();
`else
        retire(2'd0, 32'd0, 32'd0);
`endif

        // T5: reset in the middle of a request, then a stale ack while idle
        while (!imem_req) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_req_async", imem_req, 32'h0);
        check("t5_pc_async",  pc,       32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("t5_stale_req",   imem_req,   32'h1);
        check("t5_stale_valid", inst_valid, 32'h0);
        check("t5_stale_inst",  inst,       32'h13);

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            if (m_phase == M_TRAP || $urandom_range(0, 299) == 0) begin
                pulse_reset();
            end
            imem_ack   = ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            stall      = ($urandom_range(0, 3) == 0);
            npc_op     = 2'($urandom_range(0, 3));
            r          = $urandom_range(0, 15);
            imm        = (r == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            rd1        = (r == 1) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 1) == 0) imm = -imm;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
